// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad scanner.
//   state_e        : scan FSM states
//   KEY_W, DATA_W  : key code and entry word widths
//   lowest_low_row : picks the lowest-index row that reads low (active-low rows)
package keypad_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    // When several rows are low at once, the lowest row index wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce_ctr.sv
// Scan tick divider and debounce counter for the keypad scanner.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_dbc_clr     : restart the debounce count at 0
//   i_dbc_inc     : advance the debounce count by one
//   o_tick        : one-cycle pulse every CLK_DIV clocks (counter at CLK_DIV-1)
//   o_dbc_done    : debounce count has reached DEBOUNCE_TICKS-1
module keypad_debounce_ctr #(
    parameter int unsigned CLK_DIV        = 5000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_dbc_clr,
    input  logic i_dbc_inc,
    output logic o_tick,
    output logic o_dbc_done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned DBC_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [DIV_W-1:0] r_div;
    logic [DBC_W-1:0] r_dbc;
    logic             w_div_last;

    assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));
    assign o_tick     = w_div_last;
    assign o_dbc_done = (r_dbc == DBC_W'(DEBOUNCE_TICKS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dbc <= '0;
        end else if (i_dbc_clr) begin
            r_dbc <= '0;
        end else if (i_dbc_inc) begin
            r_dbc <= r_dbc + 1'b1;
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives one column low per scan tick, debounces press and
// release on the latched row, emits a one-cycle key event and shifts accepted codes
// into a 16-bit entry word (newest nibble in o_data[3:0]).
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_rows        : keypad rows, active-low
//   i_clear       : one-cycle pulse, clears o_data
//   o_cols        : column drive, active-low, one column low at a time
//   o_key_valid   : one-cycle pulse per accepted press
//   o_key_code    : {row_idx, col_idx} of the last accepted key
//   o_data        : entry word
// Build option: define KEYPAD_SYNC_EN to pass i_rows through a 2-flop synchronizer
// (adds 2 clk of latency, needs CLK_DIV >= 4).
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 5000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_rows,
    input  logic              i_clear,
    output logic [3:0]        o_cols,
    output logic              o_key_valid,
    output logic [KEY_W-1:0]  o_key_code,
    output logic [DATA_W-1:0] o_data
);

    logic [3:0]        w_rows;
    state_e            r_state, w_state_next;
    logic [1:0]        r_col, w_col_next;
    logic [1:0]        r_row, w_row_next;
    logic              w_tick, w_dbc_done, w_dbc_clr, w_dbc_inc, w_accept;
    logic              w_row_low, w_any_low;
    logic              r_key_valid;
    logic [KEY_W-1:0]  r_key_code;
    logic [DATA_W-1:0] r_data;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] r_rows_meta, r_rows_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
        end else begin
            r_rows_meta <= i_rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    assign w_rows = r_rows_sync;
`else
    assign w_rows = i_rows;
`endif

    keypad_debounce_ctr #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_dbc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_dbc_clr  (w_dbc_clr),
        .i_dbc_inc  (w_dbc_inc),
        .o_tick     (w_tick),
        .o_dbc_done (w_dbc_done)
    );

    // The column only moves on ticks, so rows sampled on a tick always belong to the
    // column that has been driven for a full tick period. Outside SCAN the column stays
    // frozen on the latched key, so r_col doubles as the latched column index.
    assign w_row_low = ~w_rows[r_row];
    assign w_any_low = ~&w_rows;

    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_dbc_clr    = 1'b0;
        w_dbc_inc    = 1'b0;
        w_accept     = 1'b0;
        if (w_tick) begin
            case (r_state)
                StScan: begin
                    if (w_any_low) begin
                        w_row_next   = lowest_low_row(w_rows);
                        w_dbc_clr    = 1'b1;
                        w_state_next = StDebounce;
                    end else begin
                        w_col_next = r_col + 2'd1;
                    end
                end
                StDebounce: begin
                    if (w_row_low) begin
                        if (w_dbc_done) begin
                            w_accept     = 1'b1;
                            w_state_next = StHeld;
                        end else begin
                            w_dbc_inc = 1'b1;
                        end
                    end else begin
                        w_state_next = StScan;
                        w_col_next   = r_col + 2'd1;
                    end
                end
                StHeld: begin
                    if (!w_row_low) begin
                        w_dbc_clr    = 1'b1;
                        w_state_next = StRelease;
                    end
                end
                StRelease: begin
                    if (!w_row_low) begin
                        if (w_dbc_done) begin
                            w_state_next = StScan;
                            w_col_next   = r_col + 2'd1;
                        end else begin
                            w_dbc_inc = 1'b1;
                        end
                    end else begin
                        // Bounce during release: back to held without a new event.
                        w_state_next = StHeld;
                    end
                end
                default: w_state_next = StScan;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StScan;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_col       <= w_col_next;
            r_row       <= w_row_next;
            r_key_valid <= w_accept;
            if (w_accept) r_key_code <= {r_row, r_col};
        end
    end

    // Shift happens while o_key_valid is high, using the code it presents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (r_key_valid && i_clear) begin
            r_data <= {{(DATA_W - KEY_W){1'b0}}, r_key_code};
        end else if (r_key_valid) begin
            r_data <= {r_data[DATA_W-KEY_W-1:0], r_key_code};
        end else if (i_clear) begin
            r_data <= '0;
        end
    end

    assign o_cols      = ~(4'b0001 << r_col);
    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_data      = r_data;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner with CLK_DIV=4, DEBOUNCE_TICKS=3. A keypad model pulls a
// row low only while the pressed key's column is driven. Expected events go into a
// scoreboard queue; a monitor pops one on every o_key_valid pulse.
module tb_hex_keypad_scanner;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DBT     = 3;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        kv;
    logic [3:0]  kc;
    logic [15:0] data;
    logic [15:0] pressed;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_data;
    int          n_checks;
    int          n_pass;
    int          n_events;

    hex_keypad_scanner #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DBT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rows      (rows),
        .i_clear     (clear),
        .o_cols      (cols),
        .o_key_valid (kv),
        .o_key_code  (kc),
        .o_data      (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: key code {row, col}.
    always_comb begin
        rows = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && !cols[k[1:0]]) rows[k[3:2]] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [3:0] code, input logic with_clear);
        exp_t e;
        model_data = with_clear ? {12'h000, code} : {model_data[11:0], code};
        e.code = code;
        e.data = model_data;
        sb_q.push_back(e);
    endtask

    // Returns at the first negedge on which column c is driven after a column change.
    task automatic wait_col(input logic [1:0] c);
        int n;
        n = 0;
        while (cols[c] === 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (cols[c] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("col_reached", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_kv(output int cyc);
        cyc = 0;
        while (kv !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("event_arrived", 32'(kv), 32'd1);
    endtask

    task automatic press_key(input logic [3:0] code);
        int cyc;
        wait_col(code[1:0]);
        push_exp(code, 1'b0);
        pressed[code] = 1'b1;
        wait_kv(cyc);
        check("press_latency", 32'(cyc), 32'd16);
        pressed[code] = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (kv === 1'b1) begin
                n_events++;
                check("event_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("key_code", 32'(kc), 32'(e.code));
                    @(negedge clk);
                    check("key_valid_one_cycle", 32'(kv), 32'd0);
                    check("data", 32'(data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] col_seq [5];
        int         cyc;
        int         ev_before;

        col_seq    = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        n_checks   = 0;
        n_pass     = 0;
        n_events   = 0;
        model_data = 16'h0000;
        pressed    = 16'h0000;
        clear      = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cols", 32'(cols), 32'(4'hE));
        check("reset_key_valid", 32'(kv), 32'd0);
        check("reset_key_code", 32'(kc), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        rst = 1'b0;

        // 1: idle scan, one column step per 4 clk.
        for (int k = 0; k < 5; k++) begin
            check("idle_cols", 32'(cols), 32'(col_seq[k]));
            repeat (4) @(negedge clk);
        end

        // 2: key 6 (row1, col2) held for many ticks.
        wait_col(2'd2);
        push_exp(4'h6, 1'b0);
        pressed[6] = 1'b1;
        wait_kv(cyc);
        check("press_latency", 32'(cyc), 32'd16);
        for (int t = 0; t < 6; t++) begin
            repeat (4) @(negedge clk);
            check("cols_frozen", 32'(cols), 32'(4'b1011));
        end
        check("held_key_code", 32'(kc), 32'h6);
        check("held_data", 32'(data), 32'h0006);
        check("held_single_event", 32'(n_events), 32'd1);
        pressed[6] = 1'b0;
        repeat (32) @(negedge clk);

        // 3: bounce on key 9 (row2, col1): low 1 tick, high 1 tick, then steady.
        wait_col(2'd1);
        push_exp(4'h9, 1'b0);
        pressed[9] = 1'b1;
        repeat (4) @(negedge clk);
        pressed[9] = 1'b0;
        repeat (4) @(negedge clk);
        pressed[9] = 1'b1;
        wait_kv(cyc);
        check("bounce_latency", 32'(cyc), 32'd28);
        pressed[9] = 1'b0;
        repeat (32) @(negedge clk);
        check("bounce_event_count", 32'(n_events), 32'd2);

        // 4: keys 1..5 in sequence.
        for (int k = 1; k <= 5; k++) press_key(4'(k));
        check("seq_data", 32'(data), 32'h2345);
        check("seq_key_code", 32'(kc), 32'h5);

        // 5: clear coincident with key A's event, then clear alone.
        wait_col(2'd2);
        push_exp(4'hA, 1'b1);
        pressed[10] = 1'b1;
        wait_kv(cyc);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pressed[10] = 1'b0;
        repeat (32) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_data = 16'h0000;
        check("clear_alone", 32'(data), 32'h0000);

        // 6: rows 0 and 2 low together on col3 -> row 0 wins.
        wait_col(2'd3);
        push_exp(4'h3, 1'b0);
        pressed[3]  = 1'b1;
        pressed[11] = 1'b1;
        wait_kv(cyc);
        check("multi_row_latency", 32'(cyc), 32'd16);
        pressed[3]  = 1'b0;
        pressed[11] = 1'b0;
        repeat (32) @(negedge clk);

        // Reset while key 0 is in debounce.
        wait_col(2'd0);
        pressed[0] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_cols", 32'(cols), 32'(4'hE));
        check("midrst_key_valid", 32'(kv), 32'd0);
        check("midrst_key_code", 32'(kc), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        @(negedge clk);
        pressed[0] = 1'b0;
        repeat (2) @(negedge clk);
        ev_before = n_events;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no_event_after_reset", 32'(n_events), 32'(ev_before));
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
